mem_read_streamer: RTL and testbench

MEM_READ_STREAMER -- requirements
Module: mem_read_streamer

---
 rtl/mem_read_streamer_pkg.sv | 13 +
 rtl/stream_fifo2.sv | 56 +++++
 rtl/mem_read_streamer.sv | 138 +++++++++++++
 tb/tb_mem_read_streamer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_read_streamer_pkg.sv
// Shared constants for the memory read streamer: default widths and the FSM state encoding.
package mem_read_streamer_pkg;

    localparam int unsigned DefaultAddrW = 10;
    localparam int unsigned DefaultDataW = 32;

    typedef logic [1:0] state_t;

    localparam state_t StIdle  = 2'd0;
    localparam state_t StIssue = 2'd1;
    localparam state_t StDrain = 2'd2;

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry valid/ready FIFO buffering read data between the read ports and the output stream.
module stream_fifo2
    import mem_read_streamer_pkg::*;
#(
    parameter int unsigned DATA_W = DefaultDataW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_valid,
    output logic              push_ready,
    input  logic [DATA_W-1:0] push_data,
    output logic              pop_valid,
    input  logic              pop_ready,
    output logic [DATA_W-1:0] pop_data,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] slot_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        count_q;
    logic              push;
    logic              pop;

    assign pop_valid = (count_q != 2'd0);
    // When full, a pop in the same cycle frees the head slot that the push then overwrites.
    assign push_ready = (count_q != 2'd2) || pop_ready;
    assign push = push_valid && push_ready;
    assign pop = pop_valid && pop_ready;
    assign pop_data = pop_valid ? slot_q[rd_ptr_q] : '0;
    assign count = count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q[0] <= '0;
            slot_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            if (push) begin
                slot_q[wr_ptr_q] <= push_data;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/mem_read_streamer.sv
// Burst reader: issues sequential reads to the memory or register-file port and streams the
// returned words out through a small FIFO with valid/ready flow control.
module mem_read_streamer
    import mem_read_streamer_pkg::*;
#(
    parameter int unsigned ADDR_W = DefaultAddrW,
    parameter int unsigned DATA_W = DefaultDataW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic              src_sel,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              reg_rd_en,
    output logic [ADDR_W-1:0] reg_addr,
    input  logic [DATA_W-1:0] reg_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int unsigned LenW = ADDR_W + 1;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [LenW-1:0]   issue_left_q;
    logic [LenW-1:0]   words_left_q;
    logic              src_sel_q;
    logic              in_flight_q;
    logic              done_q;

    logic              accept;
    logic              zero_start;
    logic              issue;
    logic              pop;
    logic              last_pop;
    logic [1:0]        fifo_count;
    logic              fifo_push_ready;
    logic [2:0]        pending;
    logic [DATA_W-1:0] rd_data;

    assign accept = (state_q == StIdle) && start;
    assign zero_start = accept && (length == '0);
    assign pop = out_valid && out_ready;
    assign last_pop = pop && out_last;
    assign pending = {1'b0, fifo_count} + {2'b00, in_flight_q};
    // A pop this cycle frees a slot in time for the data of a read issued now.
    assign issue = (state_q == StIssue) && (pending < ({2'b00, pop} + 3'd2));
    assign rd_data = src_sel_q ? reg_rd_data : mem_rd_data;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept && !zero_start) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (issue && (issue_left_q == LenW'(1))) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (last_pop) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            issue_left_q <= '0;
            words_left_q <= '0;
            src_sel_q    <= 1'b0;
            in_flight_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_flight_q <= issue;
            done_q      <= zero_start || ((state_q == StDrain) && last_pop);
            if (accept && !zero_start) begin
                addr_q       <= base_addr;
                issue_left_q <= length;
                words_left_q <= length;
                src_sel_q    <= src_sel;
            end else begin
                if (issue) begin
                    addr_q       <= addr_q + 1'b1;
                    issue_left_q <= issue_left_q - 1'b1;
                end
                if (pop) begin
                    words_left_q <= words_left_q - 1'b1;
                end
            end
        end
    end

    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign mem_rd_en = issue && !src_sel_q;
    assign reg_rd_en = issue && src_sel_q;
    assign mem_addr = (busy && !src_sel_q) ? addr_q : '0;
    assign reg_addr = (busy && src_sel_q) ? addr_q : '0;
    assign out_last = out_valid && (words_left_q == LenW'(1));

    stream_fifo2 #(
        .DATA_W(DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_valid(in_flight_q),
        .push_ready(fifo_push_ready),
        .push_data (rd_data),
        .pop_valid (out_valid),
        .pop_ready (out_ready),
        .pop_data  (out_data),
        .count     (fifo_count)
    );

    // Occupancy accounting guarantees the FIFO can always take returning data.
    push_never_blocked: assert property (
        @(posedge clk) disable iff (rst) in_flight_q |-> fifo_push_ready
    );

endmodule

// File: tb/tb_mem_read_streamer.sv
// Bench for mem_read_streamer: table-driven and random bursts checked against a burst-level
// model (address = base + i mod 1024, word i = selected array at that address).
module tb_mem_read_streamer;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic          src_sel;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rd_data;
    logic          reg_rd_en;
    logic [AW-1:0] reg_addr;
    logic [DW-1:0] reg_rd_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          done;

    logic [DW-1:0] mem_arr [DEPTH];
    logic [DW-1:0] reg_arr [DEPTH];

    int n_checks;
    int n_pass;

    typedef struct {
        logic [AW-1:0] base;
        int            len;
        bit            src;
        int            ready_mode;  // 0: always ready, 1: toggling 1010, 2: random
        int            restart_at;  // cycle of a spurious second start, -1 for none
        int            rst_after;   // words delivered before reset, -1 for none
        int            exp_words;
    } vec_t;

    vec_t vecs[$];

    mem_read_streamer #(
        .ADDR_W(AW),
        .DATA_W(DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .length     (length),
        .src_sel    (src_sel),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rd_data(mem_rd_data),
        .reg_rd_en  (reg_rd_en),
        .reg_addr   (reg_addr),
        .reg_rd_data(reg_rd_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Both read ports return data one cycle after the strobe; garbage otherwise.
    always @(posedge clk) begin
        mem_rd_data <= mem_rd_en ? mem_arr[mem_addr] : $urandom;
        reg_rd_data <= reg_rd_en ? reg_arr[reg_addr] : $urandom;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {6'b0, out_valid, out_last, mem_rd_en, reg_rd_en, busy, done,
                mem_addr, reg_addr, out_data};
    endfunction

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_burst(input vec_t v);
        int            t;
        int            n_rd;
        int            n_hs;
        int            n_done;
        int            first_valid;
        int            last_hs_t;
        int            done_t;
        int            max_out;
        int            budget;
        bit            ended;
        bit            stalled;
        logic [DW-1:0] held;
        logic [DW-1:0] exp_word;
        logic [AW-1:0] exp_addr;
        logic [AW-1:0] sel_addr;
        logic [AW-1:0] oth_addr;
        logic          sel_en;
        logic          oth_en;
        logic          rdy;
        int            widx;

        n_rd = 0;
        n_hs = 0;
        n_done = 0;
        first_valid = -1;
        last_hs_t = -1;
        done_t = -1;
        max_out = 0;
        ended = 1'b0;
        stalled = 1'b0;
        held = '0;
        budget = 8 * v.len + 50;

        @(negedge clk);
        start = 1'b1;
        base_addr = v.base;
        length = 11'(v.len);
        src_sel = v.src;
        out_ready = 1'b1;

        for (t = 0; t < budget && !ended; t++) begin
            @(negedge clk);
            // Scramble the request inputs so any late sampling shows up.
            start = (t == v.restart_at);
            base_addr = AW'($urandom);
            length = 11'($urandom_range(0, 1024));
            src_sel = 1'($urandom);
            case (v.ready_mode)
                0:       rdy = 1'b1;
                1:       rdy = ((t % 2) == 0);
                default: rdy = 1'($urandom);
            endcase
            out_ready = rdy;
            #1;
            sel_en = v.src ? reg_rd_en : mem_rd_en;
            oth_en = v.src ? mem_rd_en : reg_rd_en;
            sel_addr = v.src ? reg_addr : mem_addr;
            oth_addr = v.src ? mem_addr : reg_addr;
            check("other_port_idle", {53'b0, oth_en, oth_addr}, 64'd0);
            if (sel_en) begin
                exp_addr = AW'((int'(v.base) + n_rd) % DEPTH);
                check("rd_addr", 64'(sel_addr), 64'(exp_addr));
                if (v.ready_mode == 0) check("rd_cycle", 64'(t), 64'(n_rd));
                n_rd++;
            end
            if (stalled) check("stall_hold", {31'b0, out_valid, out_data}, {31'b0, 1'b1, held});
            if (out_valid && first_valid < 0) first_valid = t;
            if (out_valid && rdy) begin
                widx = (int'(v.base) + n_hs) % DEPTH;
                exp_word = v.src ? reg_arr[widx] : mem_arr[widx];
                check("word_data", 64'(out_data), 64'(exp_word));
                check("word_last", 64'(out_last), 64'(n_hs == v.len - 1));
                check("busy_high", 64'(busy), 64'd1);
                n_hs++;
                last_hs_t = t;
            end
            stalled = out_valid && !rdy;
            held = out_data;
            if (n_rd - n_hs > max_out) max_out = n_rd - n_hs;
            if (done) begin
                n_done++;
                done_t = t;
                check("done_busy_low", 64'(busy), 64'd0);
                ended = 1'b1;
            end
            if (v.rst_after >= 0 && n_hs == v.rst_after) ended = 1'b1;
        end
        start = 1'b0;

        if (v.rst_after >= 0) begin
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            #1;
            check("reset_outputs", all_outs(), 64'd0);
            rst = 1'b0;
            @(negedge clk);
            #1;
            check("post_reset_idle", {61'b0, out_valid, busy, done}, 64'd0);
            check("reset_word_count", 64'(n_hs), 64'(v.exp_words));
            check("reset_no_done", 64'(n_done), 64'd0);
        end else if (!ended) begin
            check("burst_timeout", 64'(ended), 64'd1);
            pulse_reset();
        end else begin
            check("word_count", 64'(n_hs), 64'(v.exp_words));
            check("read_count", 64'(n_rd), 64'(v.len));
            check("done_after_last", 64'(done_t), 64'(last_hs_t + 1));
            check("max_outstanding", 64'(max_out <= 2), 64'd1);
            check("first_valid", 64'(first_valid), 64'd2);
            if (v.ready_mode == 0) check("done_cycle", 64'(done_t), 64'(v.len + 2));
            @(negedge clk);
            #1;
            check("done_pulse", {62'b0, done, busy}, 64'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rv;
        n_checks = 0;
        n_pass = 0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem_arr[i] = $urandom;
            reg_arr[i] = $urandom;
        end

        vecs.push_back('{10'h010, 4, 1'b0, 0, -1, -1, 4});
        vecs.push_back('{10'h3FE, 4, 1'b1, 0, -1, -1, 4});
        vecs.push_back('{10'h055, 8, 1'b0, 1, -1, -1, 8});
        vecs.push_back('{10'h200, 8, 1'b1, 1, -1, -1, 8});
        vecs.push_back('{10'h3FF, 1, 1'b0, 2, -1, -1, 1});
        vecs.push_back('{10'h123, 8, 1'b0, 0, -1, 3, 3});
        vecs.push_back('{10'h100, 2, 1'b0, 0, -1, -1, 2});
        vecs.push_back('{10'h040, 6, 1'b0, 0, 2, -1, 6});
        vecs.push_back('{10'h300, 10, 1'b1, 2, 5, -1, 10});
        vecs.push_back('{10'h3F0, 1024, 1'b0, 2, -1, -1, 1024});

        rst = 1'b1;
        start = 1'b0;
        base_addr = '0;
        length = '0;
        src_sel = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset_state", all_outs(), 64'd0);
        rst = 1'b0;

        // Zero-length start: no reads, done one cycle later, never busy.
        @(negedge clk);
        start = 1'b1;
        base_addr = 10'h2AA;
        length = '0;
        src_sel = 1'b0;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            check("zero_len_done", 64'(done), 64'(t == 0));
            check("zero_len_busy", 64'(busy), 64'd0);
            check("zero_len_strobe", {62'b0, mem_rd_en, reg_rd_en}, 64'd0);
        end

        foreach (vecs[i]) run_burst(vecs[i]);

        for (int i = 0; i < 16; i++) begin
            rv.base = AW'($urandom_range(0, DEPTH - 1));
            rv.len = $urandom_range(1, 40);
            rv.src = 1'($urandom);
            rv.ready_mode = $urandom_range(0, 2);
            rv.restart_at = ($urandom_range(0, 1) == 1) ? $urandom_range(0, rv.len - 1) : -1;
            rv.rst_after = -1;
            rv.exp_words = rv.len;
            run_burst(rv);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
